// File: rtl/frame_tx_buffer.sv
// frame_tx_buffer: whole-frame word buffer feeding a byte-wide host link,
// with keep-alive sync sequences inserted at idle frame boundaries.
module frame_tx_buffer #(
    parameter int WORD_W     = 16,
    parameter int DEPTH_LOG2 = 12,
    parameter int FRAME_LOG2 = 3,
    parameter int SYNC_W     = 17,
    parameter int SYNC_FF    = 3,
    parameter int OVF_W      = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync,
    input  logic                  in_valid,
    input  logic [WORD_W-1:0]     in_word,
    input  logic                  in_flush,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [15:0]           frames_dropped
);
    localparam int PW  = DEPTH_LOG2 + 1;
    localparam int NB  = WORD_W / 8;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int SCW = $clog2(SYNC_FF + 2);
    localparam logic [PW-1:0]  P_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0]  P_FMASK = PW'((1 << FRAME_LOG2) - 1);
    localparam logic [BW-1:0]  P_BLAST = BW'(NB - 1);
    localparam logic [SCW-1:0] P_SLAST = SCW'(SYNC_FF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_SYNC
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
    logic [WORD_W-1:0] r_rdata;

    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_cp;
    logic [PW-1:0]     r_rp;
    logic              r_drop;
    logic [SYNC_W-1:0] r_timer;
    logic [OVF_W-1:0]  r_ovf;
    logic [15:0]       r_fdrop;
    logic [PW-1:0]     r_level;
    logic [7:0]        r_odata;
    logic              r_ovalid;
    logic [BW-1:0]     r_bidx;
    logic [SCW-1:0]    r_scnt;

    logic              w_full;
    logic              w_wr;
    logic              w_ovf_ev;
    logic              w_commit;
    logic [PW-1:0]     w_wp_inc;
    logic [PW-1:0]     w_cp_nxt;
    logic [PW-1:0]     w_rp_p1;
    logic [PW-1:0]     w_rp_nxt;
    logic              w_slot;
    logic              w_xfer;
    logic              w_last;
    logic              w_tmr_zero;
    logic              w_sync_go;
    logic              w_more;
    logic              w_due;
    logic              w_load;
    logic [7:0]        w_byte;
    logic              w_rp_step;
    logic [BW-1:0]     w_bidx_nxt;
    logic [SCW-1:0]    w_scnt_nxt;
    logic              w_timer_load;

    assign w_full   = (r_wp - r_rp) == P_DEPTH;
    assign w_wr     = in_valid && !r_drop && !in_flush && !w_full;
    assign w_ovf_ev = in_valid && !r_drop && !in_flush && w_full;
    assign w_wp_inc = r_wp + PW'(1);
    assign w_commit = w_wr && ((w_wp_inc & P_FMASK) == '0);
    assign w_cp_nxt = w_commit ? w_wp_inc : r_cp;

    assign w_rp_p1    = r_rp + PW'(1);
    assign w_rp_nxt   = w_rp_step ? w_rp_p1 : r_rp;
    assign w_slot     = !r_ovalid || out_ready;
    assign w_xfer     = r_ovalid && out_ready;
    assign w_last     = r_bidx == P_BLAST;
    assign w_tmr_zero = r_timer == '0;
    assign w_sync_go  = (r_bidx == '0) && ((r_rp & P_FMASK) == '0) &&
                        sync && w_tmr_zero;
    assign w_more     = r_cp != w_rp_p1;
    assign w_due      = sync && w_tmr_zero &&
                        ((w_rp_p1 & P_FMASK) == '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_byte       = 8'h00;
        w_rp_step    = 1'b0;
        w_bidx_nxt   = r_bidx;
        w_scnt_nxt   = r_scnt;
        w_timer_load = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_sync_go) begin
                    w_state_nxt = S_SYNC;
                end else if (r_cp != r_rp) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_slot) begin
                    w_load = 1'b1;
                    w_byte = r_rdata[8*r_bidx +: 8];
                    if (w_last) begin
                        w_rp_step  = 1'b1;
                        w_bidx_nxt = '0;
                        if (!w_more || w_due) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bidx_nxt = r_bidx + BW'(1);
                    end
                end
            end
            S_SYNC: begin
                // once every byte is loaded, wait for the 0x7F to leave
                if (r_scnt <= P_SLAST) begin
                    if (w_slot) begin
                        w_load     = 1'b1;
                        w_byte     = (r_scnt == P_SLAST) ? 8'h7F : 8'hFF;
                        w_scnt_nxt = r_scnt + SCW'(1);
                    end
                end else if (w_xfer) begin
                    w_timer_load = 1'b1;
                    w_scnt_nxt   = '0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // read address follows the next read pointer so words stream gap-free
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp[DEPTH_LOG2-1:0]] <= in_word;
        end
        r_rdata <= r_mem[w_rp_nxt[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp     <= '0;
            r_cp     <= '0;
            r_rp     <= '0;
            r_drop   <= 1'b0;
            r_timer  <= '0;
            r_ovf    <= '0;
            r_fdrop  <= '0;
            r_level  <= '0;
            r_odata  <= 8'h00;
            r_ovalid <= 1'b0;
            r_bidx   <= '0;
            r_scnt   <= '0;
        end else begin
            if (in_flush) begin
                r_wp   <= r_cp;
                r_drop <= 1'b0;
            end else if (w_ovf_ev) begin
                r_wp   <= r_cp;
                r_drop <= 1'b1;
            end else if (w_wr) begin
                r_wp <= w_wp_inc;
            end
            r_cp    <= w_cp_nxt;
            r_rp    <= w_rp_nxt;
            r_level <= w_cp_nxt - w_rp_nxt;
            if (w_ovf_ev) begin
                r_ovf <= '1;
            end else if (r_ovf != '0) begin
                r_ovf <= r_ovf - OVF_W'(1);
            end
            if (w_ovf_ev && (r_fdrop != 16'hFFFF)) begin
                r_fdrop <= r_fdrop + 16'd1;
            end
            if (w_timer_load) begin
                r_timer <= '1;
            end else if (!w_tmr_zero) begin
                r_timer <= r_timer - SYNC_W'(1);
            end
            if (w_load) begin
                r_odata  <= w_byte;
                r_ovalid <= 1'b1;
            end else if (w_xfer) begin
                r_ovalid <= 1'b0;
            end
            r_bidx <= w_bidx_nxt;
            r_scnt <= w_scnt_nxt;
        end
    end

    assign out_data       = r_odata;
    assign out_valid      = r_ovalid;
    assign level          = r_level;
    assign overflow       = r_ovf != '0;
    assign frames_dropped = r_fdrop;

endmodule

// File: tb/tb_frame_tx_buffer.sv
// tb_frame_tx_buffer: directed and randomized checks of frame_tx_buffer
// against a queue-based model of frame commit and byte streaming.
module tb_frame_tx_buffer;
    localparam int WW    = 16;
    localparam int DL    = 6;
    localparam int FL    = 3;
    localparam int SW    = 10;
    localparam int SFF   = 3;
    localparam int OW    = 8;
    localparam int DEPTH = 1 << DL;
    localparam int FR    = 1 << FL;
    localparam int NB    = WW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          sync;
    logic          in_valid;
    logic [WW-1:0] in_word;
    logic          in_flush;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DL:0]   level;
    logic          overflow;
    logic [15:0]   frames_dropped;

    always #5 clk = ~clk;

    frame_tx_buffer #(
        .WORD_W(WW), .DEPTH_LOG2(DL), .FRAME_LOG2(FL),
        .SYNC_W(SW), .SYNC_FF(SFF), .OVF_W(OW)
    ) dut (
        .clk(clk), .rst(rst), .sync(sync),
        .in_valid(in_valid), .in_word(in_word), .in_flush(in_flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow),
        .frames_dropped(frames_dropped)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] expq[$];
    int txc[$];
    int acc = 0;
    bit mon_en = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] held;
    int max_level = 0;
    logic [WW-1:0] part[$];
    int committed = 0;
    bit mdrop = 1'b0;
    int mdropped = 0;
    int a0, t7f, vis, lat, gaps, n, words, occ, gap;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(held));
            end
            if (out_valid && out_ready && mon_en) begin
                if (expq.size() == 0)
                    chk("extra_byte", 32'(expq.size()), 32'd1);
                else
                    chk("stream", 32'(out_data), 32'(expq.pop_front()));
                txc.push_back(cyc);
                acc++;
            end
            stall_prev = out_valid && !out_ready;
            held = out_data;
            if (int'(level) > max_level) max_level = int'(level);
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic mwrite(input logic [WW-1:0] w);
        if (mdrop) return;
        if (part.size() + committed - acc / NB >= DEPTH) begin
            mdrop = 1'b1;
            part.delete();
            mdropped++;
            return;
        end
        part.push_back(w);
        if (part.size() == FR) begin
            foreach (part[i])
                for (int b = 0; b < NB; b++)
                    expq.push_back(part[i][8*b +: 8]);
            committed += FR;
            part.delete();
        end
    endtask

    task automatic wr(input logic [WW-1:0] w);
        in_valid = 1'b1;
        in_word = w;
        mwrite(w);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        in_flush = 1'b1;
        in_valid = 1'b1;
        in_word = 16'h5555;
        part.delete();
        mdrop = 1'b0;
        tick();
        in_flush = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(expq.size()), 32'd0);
    endtask

    task automatic push_sync();
        for (int i = 0; i < SFF; i++) expq.push_back(8'hFF);
        expq.push_back(8'h7F);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; in_valid = 1'b0; in_flush = 1'b0;
        in_word = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drops", 32'(frames_dropped), 32'd0);

        // first sync right after reset, then the quiet interval
        sync = 1'b1; out_ready = 1'b1; mon_en = 1'b1;
        push_sync();
        txc.delete();
        rst = 1'b0;
        drain(20, "sync1_drain");
        chk("sync1_count", 32'(txc.size()), 32'd4);
        if (txc.size() == 4) chk("sync1_gap", 32'(txc[3] - txc[0]), 32'd3);
        t7f = (txc.size() > 0) ? txc[txc.size()-1] : 0;
        txc.delete();
        vis = 0;
        repeat (1000) begin
            tick();
            if (out_valid) vis++;
        end
        chk("sync_quiet", 32'(vis), 32'd0);
        push_sync();
        drain(100, "sync2_drain");
        chk("sync2_count", 32'(txc.size()), 32'd4);
        gap = (txc.size() > 0) ? txc[0] - t7f : 0;
        chk("sync2_min", 32'(gap >= (1 << SW) - 1), 32'd1);
        chk("sync2_max", 32'(gap <= (1 << SW) + 16), 32'd1);
        sync = 1'b0;
        acc = 0;
        committed = 0;

        // one frame, latency and gap-free streaming
        txc.delete();
        max_level = 0;
        for (int i = 0; i < FR; i++) wr(16'h0100 + 16'(i));
        lat = 0;
        while (!out_valid && lat < 4) begin
            tick();
            lat++;
        end
        chk("first_latency", 32'(lat <= 3), 32'd1);
        drain(50, "seq_drain");
        chk("seq_count", 32'(txc.size()), 32'(FR * NB));
        gaps = 0;
        for (int i = 1; i < txc.size(); i++)
            if (txc[i] - txc[i-1] != 1) gaps++;
        chk("seq_no_bubble", 32'(gaps), 32'd0);
        chk("seq_level_peak", 32'(max_level), 32'(FR));
        tick();
        chk("seq_level_end", 32'(level), 32'd0);

        // partial frame flushed, flush beats a concurrent word
        a0 = acc;
        max_level = 0;
        for (int i = 0; i < 5; i++) wr(16'h1230 + 16'(i));
        do_flush();
        for (int i = 0; i < FR; i++) wr(16'hAAAA);
        drain(60, "flush_drain");
        chk("flush_bytes", 32'(acc - a0), 32'(FR * NB));
        chk("flush_level_peak", 32'(max_level), 32'(FR));
        tick();
        chk("flush_level_end", 32'(level), 32'd0);

        // fill to full at a frame boundary, then overflow
        out_ready = 1'b0;
        a0 = acc;
        for (int i = 0; i < DEPTH; i++) wr(16'($urandom));
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_no_ovf", 32'(overflow), 32'd0);
        wr(16'($urandom));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops", 32'(frames_dropped), 32'(mdropped));
        for (int i = 0; i < 5; i++) wr(16'($urandom));
        chk("drop_level", 32'(level), 32'(DEPTH));
        chk("drop_drops", 32'(frames_dropped), 32'd1);
        do_flush();
        out_ready = 1'b1;
        drain(300, "full_drain");
        chk("full_bytes", 32'(acc - a0), 32'(DEPTH * NB));
        tick();
        chk("full_level_end", 32'(level), 32'd0);
        repeat (200) tick();
        chk("ovf_expired", 32'(overflow), 32'd0);
        chk("drops_held", 32'(frames_dropped), 32'd1);

        // random backpressure with continuous frames and pointer wrap
        a0 = acc;
        words = 0;
        while (words < 40 * FR) begin
            out_ready = 1'($urandom_range(0, 1));
            occ = part.size() + committed - acc / NB;
            if ($urandom_range(0, 3) != 0 && occ < DEPTH - 1) begin
                in_valid = 1'b1;
                in_word = 16'($urandom);
                mwrite(in_word);
                words++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("rand_drain", 32'(expq.size()), 32'd0);
        chk("rand_bytes", 32'(acc - a0), 32'(40 * FR * NB));
        out_ready = 1'b1;

        // reset in the middle of a burst
        for (int i = 0; i < 2 * FR; i++) wr(16'($urandom));
        repeat (5) tick();
        chk("burst_active", 32'(out_valid), 32'd1);
        rst = 1'b1;
        mon_en = 1'b0;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        rst = 1'b0;
        expq.delete();
        part.delete();
        vis = 0;
        repeat (10) begin
            tick();
            if (out_valid) vis++;
        end
        chk("post_rst_quiet", 32'(vis), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
